apb_m_bridge: RTL and testbench
===============================

// Module: apb_m_bridge
// PURPOSE
//  - APB master stage sitting directly upstream of the 8-bit APB slave (16 x 8b register file).
//  - Accepts one command at a time from a valid/ready request port and runs the APB SETUP/ACCESS sequence.
//  - Waits for pready, then returns read data and the error flag on a valid/ready response port.
// PARAMETERS
//  ADDR_W     32  paddr / cmd_addr width
//  DATA_W     8   pwdata / prdata / cmd_wdata / rsp_rdata width
//  TIMEOUT    16  max ACCESS cycles without pready before abort (only with APB_TIMEOUT_EN)
// PORTS
//  pclk       in   1       clock, all logic on rising edge
//  preset     in   1       asynchronous reset, active-high
//  cmd_valid  in   1       command request
//  cmd_ready  out  1       command accepted when cmd_valid && cmd_ready
//  cmd_write  in   1       1=write, 0=read
//  cmd_addr   in   ADDR_W  target address
//  cmd_wdata  in   DATA_W  write data (ignored for reads)
//  rsp_valid  out  1       response available
//  rsp_ready  in   1       response consumed when rsp_valid && rsp_ready
//  rsp_rdata  out  DATA_W  read data; 0 for writes and for errored reads
//  rsp_err    out  1       pslverr sampled with pready (or timeout abort)
//  paddr      out  ADDR_W  APB address
//  psel       out  1       APB select
//  penable    out  1       APB enable
//  pwrite     out  1       APB direction
//  pwdata     out  DATA_W  APB write data
//  prdata     in   DATA_W  APB read data
//  pready     in   1       APB ready (slave may drive combinationally)
//  pslverr    in   1       APB slave error
// BEHAVIOUR
//  - All outputs registered. Reset values: cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//    psel=0, penable=0, pwrite=0, paddr=0, pwdata=0. cmd_ready rises on the first edge after reset release.
//  - FSM states: IDLE, SETUP, ACCESS, RESP.
//  - IDLE: cmd_ready=1. On accept at edge T: latch addr/write/wdata onto paddr/pwrite/pwdata, cmd_ready=0, -> SETUP.
//  - SETUP (cycle T+1): psel=1, penable=0. pready/pslverr ignored. -> ACCESS unconditionally.
//  - ACCESS (cycle T+2..): psel=1, penable=1, paddr/pwrite/pwdata stable. Stays while pready=0.
//    On the edge where pready=1: rsp_rdata <= pwrite ? 0 : (pslverr ? 0 : prdata); rsp_err <= pslverr;
//    psel<=0, penable<=0, rsp_valid<=1, -> RESP.
//    Zero-wait slave: 3 cycles from accept to rsp_valid.
//  - RESP: rsp_valid/rsp_rdata/rsp_err held stable until rsp_ready=1. On that edge rsp_valid<=0, cmd_ready<=1, -> IDLE.
//    rsp_ready=1 on the first RESP cycle is legal (1-cycle RESP).
//  - No back-to-back: at most one outstanding command. cmd_valid while cmd_ready=0 is ignored; no state is touched.
//  - Address is not range-checked; out-of-range addresses (>15 for the 16-entry slave) are passed through and reported via rsp_err.
//  - paddr/pwrite/pwdata keep their last values in IDLE/RESP (no toggling when psel=0).
//  - Reset mid-transfer (any state): all outputs return to reset values asynchronously; the in-flight command is dropped with no response.
//  - Unused/illegal state encoding -> IDLE with reset output values.
// CONFIGURATION
//  - APB_TIMEOUT_EN defined: a counter clears on SETUP->ACCESS and increments each ACCESS cycle with pready=0.
//    When the counter reaches TIMEOUT with pready still 0: abort, psel=0, penable=0, rsp_err=1, rsp_rdata=0, -> RESP.
//    If pready=1 on that same edge, pready wins (normal completion).
//  - APB_TIMEOUT_EN undefined: no counter; ACCESS waits for pready indefinitely; TIMEOUT unused.
// TESTING
//  1. Write addr=3 data=0xA5 to the zero-wait slave -> psel at T+1, penable at T+2,
//     rsp_valid at T+3 with rsp_err=0 and rsp_rdata=0.
//  2. Read back addr=3 -> rsp_rdata=0xA5, rsp_err=0; paddr/pwrite stable across SETUP and ACCESS.
//  3. Write addr=20 -> rsp_err=1; a following read of addr=20 -> rsp_err=1, rsp_rdata=0.
//  4. Slave holding pready=0 for 4 ACCESS cycles -> penable held for 5 cycles, single response;
//     rsp_ready low for 3 cycles -> rsp_valid/rsp_rdata held, cmd_ready=0 throughout.
//  5. Assert preset during ACCESS -> psel/penable/rsp_valid=0 immediately;
//     after release, cmd_ready=1 and a new read of addr=3 completes normally.
//  6. With APB_TIMEOUT_EN and pready tied 0 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0, psel drops.

Source files
------------

// File: rtl/apb_m_bridge.sv
// apb_m_bridge: single-outstanding APB master between a valid/ready command
// port and a valid/ready response port. Every output comes straight from a flop.
// Optional build macro APB_TIMEOUT_EN adds an ACCESS-phase watchdog that aborts
// the transfer after TIMEOUT cycles without pready.
module apb_m_bridge #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  // command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // APB
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;

`ifdef APB_TIMEOUT_EN
  // Counter only needs to reach TIMEOUT-1; the abort fires on that value.
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             to_hit;
  assign to_hit = (to_cnt_q == CNT_W'(TIMEOUT - 1));
`endif

  // State and output registers; async reset returns every output to idle values
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      paddr_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
`ifdef APB_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
`ifdef APB_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  // Next-state and next-output logic; everything holds unless a state says otherwise
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    paddr_d     = paddr_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
`ifdef APB_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // cmd_ready rises one edge after reset, so acceptance keys off the registered value
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          paddr_d     = cmd_addr;
          pwrite_d    = cmd_write;
          pwdata_d    = cmd_wdata;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        // pready is not looked at here: penable is still low on the bus
        penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
        to_cnt_d  = '0;
`endif
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          rsp_rdata_d = (pwrite_q || pslverr) ? '0 : prdata;
          rsp_err_d   = pslverr;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
`ifdef APB_TIMEOUT_EN
        else if (to_hit) begin
          // Slave never answered: drop the bus and report an error
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          to_cnt_d = to_cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        paddr_d     = '0;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        pwrite_d    = 1'b0;
        pwdata_d    = '0;
`ifdef APB_TIMEOUT_EN
        to_cnt_d    = '0;
`endif
      end
    endcase
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_m_bridge.sv
// tb_apb_m_bridge: drives apb_m_bridge against a 16 x 8b APB slave model with
// programmable wait states; responses are checked from a scoreboard queue.
module tb_apb_m_bridge;

  localparam int AW = 32;
  localparam int DW = 8;

  logic          pclk = 1'b0;
  logic          preset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr;

  apb_m_bridge dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // slave model: 16 registers, errors above address 15, pready after slv_waits cycles
  logic [7:0] smem [16];
  int         slv_waits = 0;
  bit         slv_hang = 1'b0;
  int         wcnt = 0;
  logic       s_acc, s_oor;
  assign s_acc   = psel && penable;
  assign s_oor   = (paddr > 32'd15);
  assign pready  = s_acc && !slv_hang && (wcnt >= slv_waits);
  assign pslverr = pready && s_oor;
  assign prdata  = (s_acc && !s_oor) ? smem[paddr[3:0]] : 8'h00;

  always @(posedge pclk) begin
    if (s_acc && !pready) wcnt <= wcnt + 1;
    else                  wcnt <= 0;
    if (pready && pwrite && !s_oor) smem[paddr[3:0]] <= pwdata;
  end

  // scoreboard
  typedef struct packed { logic [7:0] rdata; logic err; } rsp_t;
  rsp_t       sb_q[$];
  logic [7:0] shadow [16];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // one full transaction: bus phase checks, wait-state count, response hold, handshake
  task automatic run_cmd(input bit wr, input logic [31:0] a, input logic [7:0] d,
                         input int waits, input int rdly, input bit hang);
    int   t;
    int   npen;
    int   exp_pen;
    rsp_t e;
    t = 0;
    while (!cmd_ready && t < 20) begin @(negedge pclk); t++; end
    chk("cmd_ready", cmd_ready, 1);
    slv_waits = waits;
    slv_hang  = hang;
    e.err   = hang ? 1'b1 : (a > 32'd15);
    e.rdata = (wr || e.err) ? 8'h00 : shadow[a[3:0]];
    if (wr && !e.err) shadow[a[3:0]] = d;
    sb_q.push_back(e);
    exp_pen = hang ? 16 : waits + 1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    @(negedge pclk);
    // first cycle after accept: SETUP
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~a; cmd_wdata = ~d;
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_cmd_ready", cmd_ready, 0);
    chk("setup_paddr", paddr, a);
    chk("setup_pwrite", pwrite, wr);
    if (wr) chk("setup_pwdata", pwdata, d);
    @(negedge pclk);
    // first ACCESS cycle
    chk("access_penable", penable, 1);
    chk("access_paddr", paddr, a);
    chk("access_pwrite", pwrite, wr);
    npen = 0;
    for (t = 0; t < 100 && !rsp_valid; t++) begin
      if (psel && penable && paddr === a) npen++;
      @(negedge pclk);
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("penable_cycles", npen, exp_pen);
    chk("rsp_psel", psel, 0);
    chk("rsp_penable", penable, 0);
    e = sb_q.pop_front();
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("rsp_err", rsp_err, e.err);
    // hold response; a stray command must not be taken
    for (int i = 0; i < rdly; i++) begin
      if (i == 0) begin cmd_valid = 1'b1; cmd_write = ~wr; cmd_addr = a ^ 32'h5; end
      @(negedge pclk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, e.rdata);
      chk("hold_err", rsp_err, e.err);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_paddr", paddr, a);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_cmd_ready", cmd_ready, 1);
    chk("done_psel", psel, 0);
    chk("done_paddr", paddr, a);
    slv_hang = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [3:0] ra;
    logic [7:0] rd;
    @(negedge pclk);
    // reset values
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    preset = 1'b0;
    @(negedge pclk);
    chk("first_cmd_ready", cmd_ready, 1);

    // zero-wait write, readback, out-of-range write/read
    run_cmd(1'b1, 32'd3, 8'hA5, 0, 0, 1'b0);
    run_cmd(1'b0, 32'd3, 8'h00, 0, 0, 1'b0);
    run_cmd(1'b1, 32'd20, 8'h3C, 0, 0, 1'b0);
    run_cmd(1'b0, 32'd20, 8'h00, 0, 0, 1'b0);
    // slow slave and slow response consumer
    run_cmd(1'b0, 32'd3, 8'h00, 4, 3, 1'b0);

    // mixed traffic
    for (int i = 0; i < 5; i++) begin
      ra = 4'($urandom_range(0, 15));
      rd = 8'($urandom);
      run_cmd(1'b1, {28'd0, ra}, rd, $urandom_range(0, 2), $urandom_range(0, 1), 1'b0);
      run_cmd(1'b0, {28'd0, ra}, 8'h00, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    end
    run_cmd(1'b0, 32'hFFFF_0001, 8'h00, 1, 0, 1'b0);

    // reset in the middle of ACCESS
    slv_waits = 10;
    t = 0;
    while (!cmd_ready && t < 20) begin @(negedge pclk); t++; end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'd3;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    chk("pre_rst_penable", penable, 1);
    #2 preset = 1'b1;
    #1;
    chk("midrst_psel", psel, 0);
    chk("midrst_penable", penable, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    chk("midrst_paddr", paddr, 0);
    @(negedge pclk);
    preset = 1'b0;
    slv_waits = 0;
    @(negedge pclk);
    chk("postrst_cmd_ready", cmd_ready, 1);
    chk("postrst_rsp_valid", rsp_valid, 0);
    run_cmd(1'b0, 32'd3, 8'h00, 0, 0, 1'b0);

`ifdef APB_TIMEOUT_EN
    // silent slave: watchdog abort
    run_cmd(1'b0, 32'd5, 8'h00, 0, 1, 1'b1);
`endif

    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
